// File: rtl/vga_port_arbiter.sv
// Round-robin arbiter sharing the VGA adapter write port between pixel engines; all outputs registered.
// Optional grant watchdog compiled in with ARB_WATCHDOG_EN (timeout is tied low otherwise).
module vga_port_arbiter #(
    parameter int NUM_REQ  = 3,
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOUR_W = 3,
    parameter int MAX_HOLD = 20000
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ-1:0]           done,
    input  logic [NUM_REQ*X_W-1:0]       x_in,
    input  logic [NUM_REQ*Y_W-1:0]       y_in,
    input  logic [NUM_REQ*COLOUR_W-1:0]  colour_in,
    input  logic [NUM_REQ-1:0]           plot_in,
    output logic [NUM_REQ-1:0]           grant,
    output logic [X_W-1:0]               x,
    output logic [Y_W-1:0]               y,
    output logic [COLOUR_W-1:0]          colour,
    output logic                         plot,
    output logic                         busy,
    output logic                         timeout
);

    localparam int IDX_W = $clog2(NUM_REQ);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_GRANT   = 2'd1;
    localparam logic [1:0] S_RELEASE = 2'd2;

    if (NUM_REQ < 2 || MAX_HOLD < 2) begin : g_param_check
        $error("vga_port_arbiter: NUM_REQ and MAX_HOLD must both be at least 2");
    end

    logic [X_W-1:0]      x_arr   [NUM_REQ];
    logic [Y_W-1:0]      y_arr   [NUM_REQ];
    logic [COLOUR_W-1:0] col_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign x_arr[i]   = x_in[i*X_W +: X_W];
        assign y_arr[i]   = y_in[i*Y_W +: Y_W];
        assign col_arr[i] = colour_in[i*COLOUR_W +: COLOUR_W];
    end

    logic [1:0]          state_q, state_d;
    logic [IDX_W-1:0]    rr_q, rr_d;
    logic [IDX_W-1:0]    g_q, g_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [X_W-1:0]      x_q, x_d;
    logic [Y_W-1:0]      y_q, y_d;
    logic [COLOUR_W-1:0] col_q, col_d;
    logic                plot_q, plot_d;

    logic                win_vld;
    logic [IDX_W-1:0]    win_idx;
    logic [IDX_W-1:0]    g_nxt;
    logic                expire;
    logic                release_evt;

    // Scan downward so the lowest offset from rr_q overwrites last and wins.
    always_comb begin
        int cand;
        cand    = 0;
        win_vld = |req;
        win_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = int'(rr_q) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (req[cand[IDX_W-1:0]]) begin
                win_idx = cand[IDX_W-1:0];
            end
        end
    end

    assign g_nxt       = (g_q == IDX_W'(NUM_REQ - 1)) ? '0 : g_q + 1'b1;
    assign release_evt = done[g_q] || !req[g_q] || expire;

`ifdef ARB_WATCHDOG_EN
    localparam int HOLD_W = $clog2(MAX_HOLD);

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              timeout_q, timeout_d;

    assign expire    = (state_q == S_GRANT) && (hold_q == HOLD_W'(MAX_HOLD - 1));
    assign hold_d    = (state_q == S_GRANT) ? hold_q + 1'b1 : '0;
    // A done landing on the expiry cycle is an ordinary release.
    assign timeout_d = expire && !done[g_q];
    assign timeout   = timeout_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end
`else
    assign expire  = 1'b0;
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        g_d     = g_q;
        grant_d = grant_q;
        x_d     = x_q;
        y_d     = y_q;
        col_d   = col_q;
        plot_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (win_vld) begin
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    g_d              = win_idx;
                    state_d          = S_GRANT;
                end
            end
            S_GRANT: begin
                x_d    = x_arr[g_q];
                y_d    = y_arr[g_q];
                col_d  = col_arr[g_q];
                plot_d = plot_in[g_q];
                if (release_evt) begin
                    rr_d    = g_nxt;
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                grant_d = '0;
                state_d = S_IDLE;
            end
            default: begin
                grant_d = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            rr_q    <= '0;
            g_q     <= '0;
            grant_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
            col_q   <= '0;
            plot_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            g_q     <= g_d;
            grant_q <= grant_d;
            x_q     <= x_d;
            y_q     <= y_d;
            col_q   <= col_d;
            plot_q  <= plot_d;
        end
    end

    assign grant  = grant_q;
    assign x      = x_q;
    assign y      = y_q;
    assign colour = col_q;
    assign plot   = plot_q;
    assign busy   = (state_q == S_GRANT);

endmodule

// File: tb/tb_vga_port_arbiter.sv
// Randomized bench for vga_port_arbiter: engine-style stimulus, cycle-level reference model, scoreboard monitor.
module tb_vga_port_arbiter;

    localparam int N  = 3;
    localparam int XW = 8;
    localparam int YW = 7;
    localparam int CW = 3;
    localparam int MH = 8;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [N-1:0]     req_r = '0;
    logic [N-1:0]     done_r = '0;
    logic [N*XW-1:0]  x_r = '0;
    logic [N*YW-1:0]  y_r = '0;
    logic [N*CW-1:0]  c_r = '0;
    logic [N-1:0]     plot_r = '0;
    logic [N-1:0]     grant;
    logic [XW-1:0]    x;
    logic [YW-1:0]    y;
    logic [CW-1:0]    colour;
    logic             plot, busy, timeout;

    vga_port_arbiter #(.NUM_REQ(N), .X_W(XW), .Y_W(YW), .COLOUR_W(CW), .MAX_HOLD(MH)) dut (
        .clock(clock), .reset(reset), .req(req_r), .done(done_r),
        .x_in(x_r), .y_in(y_r), .colour_in(c_r), .plot_in(plot_r),
        .grant(grant), .x(x), .y(y), .colour(colour), .plot(plot),
        .busy(busy), .timeout(timeout)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          cyc;
        logic [N-1:0] grant;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [CW-1:0] c;
        logic        plot, busy, timeout;
    } exp_t;

    exp_t q[$];
    int   edge_cnt = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_push = 0;

    // Reference model: who owns the port, whether the owner is streaming or winding down.
    int            m_owner = -1;
    bit            m_streaming = 1'b0;
    bit            m_draining = 1'b0;
    int            m_rr = 0;
    int            m_hold = 0;
    logic [XW-1:0] m_x = '0;
    logic [YW-1:0] m_y = '0;
    logic [CW-1:0] m_c = '0;

    // Engine stimulus state.
    int e_len[N];
    int e_cnt[N];
    bit e_fin[N];
    int req_pct;
    int max_len;
    int fix_len;
    bit noise;

    always @(posedge clock) edge_cnt = edge_cnt + 1;

    always @(negedge clock) begin
        exp_t e;
        while (q.size() > 0 && q[0].cyc < edge_cnt) begin
            e = q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL stale_expectation: cycle %0d never compared (now %0d)", e.cyc, edge_cnt);
        end
        if (q.size() > 0 && q[0].cyc == edge_cnt) begin
            e = q.pop_front();
            n_cmp++;
            if ({grant, x, y, colour, plot, busy, timeout} !==
                {e.grant, e.x, e.y, e.c, e.plot, e.busy, e.timeout}) begin
                n_bad++;
                $display("FAIL port_outputs cyc %0d: got grant=%b x=%0d y=%0d c=%0d plot=%b busy=%b to=%b, want grant=%b x=%0d y=%0d c=%0d plot=%b busy=%b to=%b",
                         edge_cnt, grant, x, y, colour, plot, busy, timeout,
                         e.grant, e.x, e.y, e.c, e.plot, e.busy, e.timeout);
            end
        end
    end

    task automatic check_zero(input string name);
        n_cmp++;
        if ({grant, x, y, colour, plot, busy, timeout} !== '0) begin
            n_bad++;
            $display("FAIL %s: got grant=%b x=%0d y=%0d c=%0d plot=%b busy=%b to=%b, want all zero",
                     name, grant, x, y, colour, plot, busy, timeout);
        end
    endtask

    task automatic model_reset();
        m_owner = -1; m_streaming = 0; m_draining = 0; m_rr = 0; m_hold = 0;
        m_x = '0; m_y = '0; m_c = '0;
    endtask

    // One clock edge of the arbiter as described: inputs are those presented before the edge.
    task automatic model_step(output exp_t e);
        bit expire;
        e.plot = 1'b0;
        e.timeout = 1'b0;
        if (m_streaming) begin
            m_x = x_r[m_owner*XW +: XW];
            m_y = y_r[m_owner*YW +: YW];
            m_c = c_r[m_owner*CW +: CW];
            e.plot = plot_r[m_owner];
            expire = 1'b0;
`ifdef ARB_WATCHDOG_EN
            expire = (m_hold == MH - 1);
`endif
            m_hold++;
            if (done_r[m_owner] || !req_r[m_owner] || expire) begin
                e.timeout   = expire && !done_r[m_owner];
                m_rr        = (m_owner + 1) % N;
                m_streaming = 0;
                m_draining  = 1;
            end
        end else if (m_draining) begin
            m_draining = 0;
            m_owner    = -1;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (m_owner < 0 && req_r[(m_rr + k) % N]) begin
                    m_owner     = (m_rr + k) % N;
                    m_streaming = 1;
                    m_hold      = 0;
                end
            end
        end
        e.grant = (m_owner >= 0) ? N'(1 << m_owner) : '0;
        e.busy  = m_streaming;
        e.x = m_x; e.y = m_y; e.c = m_c;
    endtask

    task automatic cycle_drive();
        exp_t e;
        for (int i = 0; i < N; i++) begin
            bit owns;
            owns = m_streaming && (m_owner == i);
            done_r[i] = 1'b0;
            if (e_fin[i]) begin
                req_r[i] = 1'b0;
                e_fin[i] = 0;
            end else if (!req_r[i]) begin
                if ($urandom_range(0, 99) < req_pct) begin
                    req_r[i] = 1'b1;
                    e_cnt[i] = 0;
                    e_len[i] = (fix_len > 0) ? fix_len : $urandom_range(1, max_len);
                end
            end else if (owns) begin
                e_cnt[i]++;
                if (e_cnt[i] >= e_len[i]) begin
                    done_r[i] = 1'b1;
                    e_fin[i]  = 1;
                end else if (noise && $urandom_range(0, 49) == 0) begin
                    req_r[i] = 1'b0;
                end
            end
            if (noise && !owns && $urandom_range(0, 7) == 0) done_r[i] = 1'b1;
            x_r[i*XW +: XW] = XW'($urandom);
            y_r[i*YW +: YW] = YW'($urandom);
            c_r[i*CW +: CW] = CW'($urandom);
            plot_r[i]       = $urandom_range(0, 3) != 0;
        end
        model_step(e);
        e.cyc = edge_cnt + 1;
        q.push_back(e);
        n_push++;
    endtask

    initial begin
        int rst_due;
        for (int i = 0; i < N; i++) begin e_len[i] = 0; e_cnt[i] = 0; e_fin[i] = 0; end
        model_reset();
        repeat (3) @(posedge clock);
        #1 check_zero("reset_state");
        reset = 1'b0;

        // All engines requesting, fixed 4-cycle bursts: pure rotation.
        req_pct = 100; fix_len = 4; max_len = 4; noise = 0;
        for (int t = 0; t < 80; t++) begin
            cycle_drive();
            @(posedge clock); #1;
        end

        // Random traffic with foreign done/plot noise, dropped requests, and mid-burst resets.
        req_pct = 30; fix_len = 0; max_len = 11; noise = 1;
        rst_due = 0;
        for (int t = 0; t < 2000; t++) begin
            if (t == 600 || t == 1400) rst_due = 1;
            if (rst_due && m_streaming) begin
                rst_due = 0;
                #2 reset = 1'b1;
                #1 check_zero("reset_mid_burst");
                q.delete();
                model_reset();
                @(posedge clock); #1;
                reset = 1'b0;
            end
            cycle_drive();
            @(posedge clock); #1;
        end

        @(negedge clock);
        @(negedge clock);
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d expectations left, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
